// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clock-divider controller.
// Odd-ratio support is enabled by defining CLK_DIV_CTRL_ODD_EN.
package clk_div_pkg;

  localparam int unsigned DIV_W_DEF       = 8;
  localparam int unsigned DEFAULT_DIV_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_core.sv
// Phase counter and toggle flop producing the divided clock.
// High phase lasts floor(ratio/2) cycles, low phase the remainder.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] ratio,
  input  logic             load,
  output logic             clk_out,
  output logic             fall
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] hi_len;
  logic [DIV_W-1:0] lo_len;
  logic [DIV_W-1:0] len;
  logic             last;

  assign hi_len = ratio >> 1;
  assign lo_len = ratio - hi_len;
  assign len    = clk_out ? hi_len : lo_len;
  assign last   = (count == (len - DIV_W'(1)));
  // Combinational: asserted during the cycle whose closing edge drops clk_out.
  assign fall   = run && clk_out && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      clk_out <= 1'b0;
    end else if (!run) begin
      count   <= '0;
      clk_out <= 1'b0;
    end else if (last) begin
      count   <= '0;
      clk_out <= ~clk_out;
    end else if (load) begin
      count   <= '0;
    end else begin
      count   <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: run/drain FSM plus ratio handshake around clk_div_core.
// Define CLK_DIV_CTRL_ODD_EN to accept odd ratios >= 3; otherwise odd ratios are rejected.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [DIV_W-1:0] div_active,
  output logic             busy,
  output logic             clk_out
);

  state_e           state;
  state_e           next_state;
  logic             run;
  logic             fall;
  logic             load;
  logic             accept;
  logic             ratio_ok;
  logic             idle_load;
  logic [DIV_W-1:0] pend_div;

`ifdef CLK_DIV_CTRL_ODD_EN
  assign ratio_ok = (cfg_div >= DIV_W'(2));
`else
  assign ratio_ok = (cfg_div >= DIV_W'(2)) && !cfg_div[0];
`endif

  // Keep counting while a high pulse is in flight so it is never truncated.
  assign run       = (state == ST_DRAIN) || ((state == ST_RUN) && (enable || clk_out));
  assign accept    = cfg_valid && cfg_ready;
  assign idle_load = (state == ST_IDLE) || (next_state == ST_IDLE);
  assign load      = !cfg_ready && (fall || idle_load);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (enable) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          if (!clk_out || fall) next_state = ST_IDLE;
          else                  next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fall) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Ratio handshake: direct load when idle, otherwise hold until the next falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready  <= 1'b1;
      cfg_err    <= 1'b0;
      div_active <= DIV_W'(DEFAULT_DIV);
      pend_div   <= '0;
    end else begin
      cfg_err <= accept && !ratio_ok;
      if (accept && ratio_ok) begin
        if (idle_load) begin
          div_active <= cfg_div;
        end else begin
          pend_div  <= cfg_div;
          cfg_ready <= 1'b0;
        end
      end else if (load) begin
        div_active <= pend_div;
        cfg_ready  <= 1'b1;
      end
    end
  end

  clk_div_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .ratio   (div_active),
    .load    (load),
    .clk_out (clk_out),
    .fall    (fall)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a phase-level reference model queues expected
// outputs per cycle; a monitor pops and compares after every rising edge.
module tb_clk_div_ctrl;

  localparam int unsigned W = 8;
`ifdef CLK_DIV_CTRL_ODD_EN
  localparam bit ODD_OK = 1'b1;
`else
  localparam bit ODD_OK = 1'b0;
`endif

  typedef struct packed {
    logic         clk_out;
    logic         busy;
    logic         ready;
    logic         err;
    logic [W-1:0] div;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic         cfg_ready;
  logic         cfg_err;
  logic [W-1:0] div_active;
  logic         busy;
  logic         clk_out;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  // Reference model: state 0 idle / 1 run / 2 drain, remaining cycles of current phase
  int m_state, m_rem, m_div, m_pend;
  bit m_hi, m_pv, m_err;

  // Run lengths of clk_out as seen by the monitor
  int run_len = 0;
  int last_hi = 0;
  int last_lo = 0;
  logic prev_clk_out = 1'b0;

  clk_div_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .div_active (div_active),
    .busy       (busy),
    .clk_out    (clk_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_rem = 0; m_div = 4; m_pend = 0;
    m_hi = 1'b0; m_pv = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit cv, input int cd);
    bit running, falls, ok, accept, going_idle;
    int ns;
    running = (m_state == 2) || (m_state == 1 && (en || m_hi));
    if (running && m_rem == 0) m_rem = m_hi ? m_div / 2 : m_div - m_div / 2;
    falls = running && m_hi && (m_rem == 1);
    case (m_state)
      0:       ns = en ? 1 : 0;
      1:       ns = en ? 1 : ((!m_hi || falls) ? 0 : 2);
      default: ns = falls ? 0 : 2;
    endcase
    ok = (cd >= 2) && (ODD_OK || (cd % 2 == 0));
    accept = cv && !m_pv;
    going_idle = (m_state == 0) || (ns == 0);
    m_err = accept && !ok;
    if (accept && ok) begin
      if (going_idle) m_div = cd;
      else begin m_pend = cd; m_pv = 1'b1; end
    end else if (m_pv && (falls || going_idle)) begin
      m_div = m_pend; m_pv = 1'b0;
    end
    if (!running)        begin m_hi = 1'b0; m_rem = 0; end
    else if (m_rem == 1) begin m_hi = !m_hi; m_rem = 0; end
    else                 m_rem--;
    m_state = ns;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.clk_out = m_hi;
    e.busy    = (m_state != 0);
    e.ready   = !m_pv;
    e.err     = m_err;
    e.div     = W'(m_div);
    return e;
  endfunction

  task automatic step(input bit en, input bit cv, input int cd);
    @(negedge clk);
    rst_n = 1'b1; enable = en; cfg_valid = cv; cfg_div = W'(cd);
    model_step(en, cv, cd);
    exp_q.push_back(model_out());
  endtask

  task automatic idle_steps(input bit en, input int n);
    for (int i = 0; i < n; i++) step(en, 1'b0, 0);
  endtask

  // Asynchronous reset asserted away from any rising edge; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
    #1;
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_div_active", int'(div_active), 4);
    model_reset();
    exp_q.push_back(model_out());
  endtask

  // Advance with enable held until the model enters the first cycle of a high phase.
  task automatic wait_high_start(input string name);
    int n = 0;
    do begin
      step(1'b1, 1'b0, 0);
      n++;
    end while (!(m_hi && m_rem == 0) && n < 40);
    if (n >= 40) check({name, "_timeout"}, n, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (clk_out === prev_clk_out) run_len++;
    else begin
      if (prev_clk_out) last_hi = run_len;
      else              last_lo = run_len;
      run_len = 1;
    end
    prev_clk_out = clk_out;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("clk_out", int'(clk_out), int'(e.clk_out));
      check("busy", int'(busy), int'(e.busy));
      check("cfg_ready", int'(cfg_ready), int'(e.ready));
      check("cfg_err", int'(cfg_err), int'(e.err));
      check("div_active", int'(div_active), int'(e.div));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // Default ratio 4: 2 low / 2 high
    idle_steps(1'b1, 20);
    check("n4_high_len", last_hi, 2);
    check("n4_low_len", last_lo, 2);

    // Offer 6 during a high phase; applied at the falling edge
    wait_high_start("n6");
    step(1'b1, 1'b1, 6);
    idle_steps(1'b1, 20);
    check("n6_high_len", last_hi, 3);
    check("n6_low_len", last_lo, 3);

    // Odd ratio 5
    step(1'b1, 1'b1, 5);
    idle_steps(1'b1, 24);
    check("n5_high_len", last_hi, ODD_OK ? 2 : 3);
    check("n5_low_len", last_lo, 3);

    // Ratios 0 and 1 rejected, ratio restored to 6
    step(1'b1, 1'b1, 6);
    idle_steps(1'b1, 12);
    step(1'b1, 1'b1, 0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 1);
    idle_steps(1'b1, 20);
    check("n01_high_len", last_hi, 3);
    check("n01_low_len", last_lo, 3);

    // Drop enable one cycle into a 3-cycle high phase
    wait_high_start("drain");
    step(1'b1, 1'b0, 0);
    idle_steps(1'b0, 6);
    @(posedge clk); #2;
    check("drain_high_len", last_hi, 3);
    check("drain_busy", int'(busy), 0);
    check("drain_clk_out", int'(clk_out), 0);

    // Reset mid-high phase with a ratio pending
    wait_high_start("rst_mid");
    step(1'b1, 1'b1, 8);
    @(posedge clk); #2;
    check("pre_rst_clk_out", int'(clk_out), 1);
    check("pre_rst_cfg_ready", int'(cfg_ready), 0);
    do_reset();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 3, int'($urandom_range(0, 12)));
    end

    idle_steps(1'b0, 2);
    @(posedge clk); #3;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 8, meaning width of divide-ratio fields.
REQ-002 SHALL have parameter DEFAULT_DIV, default 4, meaning divide ratio loaded at reset (even, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port enable  input  1  run request for the divided clock.
REQ-006 SHALL have port cfg_valid  input  1  new ratio offered.
REQ-007 SHALL have port cfg_div  input  DIV_W  offered divide ratio N.
REQ-008 SHALL have port cfg_ready  output  1  controller can accept a ratio.
REQ-009 SHALL have port cfg_err  output  1  one-cycle pulse: offered ratio rejected.
REQ-010 SHALL have port div_active  output  DIV_W  ratio currently in use.
REQ-011 SHALL have port busy  output  1  state != IDLE.
REQ-012 SHALL have port clk_out  output  1  registered divided clock.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-014 IDLE: clk_out=0, phase count=0; enable=1 -> RUN next edge.
REQ-015 RUN: phase length = H=floor(N/2) while clk_out=1, L=N-H while clk_out=0; count 0..len-1, on count==len-1 toggle clk_out and clear count.
REQ-016 RUN with enable=0: clk_out=0 -> IDLE next edge; clk_out=1 -> DRAIN.
REQ-017 DRAIN: keep counting; at end of high phase clk_out->0 and -> IDLE; high pulse never truncated; enable re-asserted in DRAIN ignored until IDLE.
REQ-018 Handshake: transfer when cfg_valid && cfg_ready; cfg_ready = no ratio pending.
REQ-019 Accepted ratio <2 (or odd, see REQ-028) SHALL be discarded and cfg_err=1 on the following cycle only; div_active unchanged.
REQ-020 Valid ratio accepted in IDLE SHALL load div_active directly at the accepting edge; cfg_ready stays 1.
REQ-021 Valid ratio accepted in RUN/DRAIN SHALL be held pending; cfg_ready=0 until applied.
REQ-022 Pending ratio SHALL be applied (div_active updated, count cleared) at the edge where clk_out falls 1->0, or on entry to IDLE; cfg_ready=1 the following cycle.
REQ-023 Ratio change SHALL never alter the length of a phase already in progress.
REQ-024 Counter width DIV_W; no wrap since count < N <= 2^DIV_W-1.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, clk_out=0, count=0, cfg_err=0, pending cleared, cfg_ready=1, div_active=DEFAULT_DIV.
REQ-026 Reset mid-phase SHALL discard the partial phase and pending ratio; no other state survives.

Configuration
REQ-027 Macro CLK_DIV_CTRL_ODD_EN SHALL control odd-ratio support.
REQ-028 Without macro: odd N rejected per REQ-019. With macro: odd N>=3 accepted, high H=(N-1)/2, low L=(N+1)/2.

Structure
REQ-029 Package clk_div_pkg SHALL hold the FSM state enum, DIV_W default and DEFAULT_DIV constant.
REQ-030 Phase counter/toggle datapath SHALL be sub-module clk_div_core (inputs run, ratio, load; outputs clk_out, fall); FSM and handshake stay in clk_div_ctrl.

Verification
REQ-031 Reset, enable=1, no cfg -> div_active=4, clk_out 2 low/2 high, period 4, busy=1.
REQ-032 Running N=4, offer 6 during high phase -> cfg_ready=0, current high lasts 2, div_active=6 at falling edge, then 3 low/3 high, cfg_ready=1 next cycle.
REQ-033 Offer 5 -> without macro cfg_err one cycle, div_active=4; with macro high 2/low 3 after next falling edge.
REQ-034 Offer 0 and 1 -> cfg_err each, clk_out period unchanged.
REQ-035 Drop enable 1 cycle into a 3-cycle high phase (N=6) -> clk_out high full 3 cycles, then 0, busy=0 next edge.
REQ-036 Assert rst_n=0 mid-high phase with ratio pending -> clk_out=0 without clock edge, div_active=4, cfg_ready=1.
